// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, request record and address helpers for the m_lsu load/store unit.
package lsu_pkg;
   localparam int DMEM_BYTES_DEF = 32768;
   typedef enum logic [1:0] {SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11} size_e;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      size_e       size;
      logic        uns;
   } req_t;
   function automatic logic misaligned(input size_e s, input logic [1:0] a);
      return (s == SZ_H && a[0]) || (s == SZ_W && a != 2'b00);
   endfunction
   function automatic logic [31:0] fix_addr(input size_e s, input logic [31:0] addr);
      return s == SZ_H ? {addr[31:1], 1'b0} : s == SZ_W ? {addr[31:2], 2'b00} : addr;
   endfunction
endpackage

// File: rtl/m_lsu_align.sv
// m_lsu_align: store strobe/lane replication and load shift/extension for one access.
module m_lsu_align
   import lsu_pkg::*;
(
   input  size_e       size_i,
   input  logic [1:0]  a_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  wstrb_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o
);
   logic [31:0] sh;
   always_comb begin
      sh      = rdata_i >> {a_i, 3'b000};
      wstrb_o = size_i == SZ_B ? 4'b0001 << a_i : size_i == SZ_H ? 4'b0011 << a_i :
                size_i == SZ_W ? 4'b1111 : 4'b0000;
      wdata_o = size_i == SZ_B ? {4{wdata_i[7:0]}} : size_i == SZ_H ? {2{wdata_i[15:0]}} : wdata_i;
      ldata_o = size_i == SZ_B ? {{24{~uns_i & sh[7]}}, sh[7:0]} :
                size_i == SZ_H ? {{16{~uns_i & sh[15]}}, sh[15:0]} : sh;
   end
endmodule

// File: rtl/m_lsu.sv
// m_lsu: single-outstanding load/store unit between a valid/ready request port and a 32-bit dmem.
// Define LSU_ALIGN_CHECK_EN to reject misaligned accesses instead of forcing alignment.
module m_lsu
   import lsu_pkg::*;
#(
   parameter int DMEM_BYTES = DMEM_BYTES_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        re_o,
   output logic        we_o,
   output logic [31:0] addr_o,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   input  logic [31:0] rdata_i
);
   state_e      state_q, state_d;
   req_t        req_q, req_d;
   logic [31:0] rdata_q, rdata_d, eff_addr, wrep, ldata;
   logic        err_q, err_d, req_err, issue;
   logic [3:0]  strb;
   size_e       req_size;
   assign req_size = size_e'(req_size_i);
`ifdef LSU_ALIGN_CHECK_EN
   assign req_err  = req_size == SZ_X || req_addr_i >= 32'(DMEM_BYTES) || misaligned(req_size, req_addr_i[1:0]);
   assign eff_addr = req_addr_i;
`else
   assign req_err  = req_size == SZ_X || req_addr_i >= 32'(DMEM_BYTES);
   assign eff_addr = fix_addr(req_size, req_addr_i);
`endif
   m_lsu_align u_align (
      .size_i  (req_q.size),
      .a_i     (req_q.addr[1:0]),
      .uns_i   (req_q.uns),
      .wdata_i (req_q.wdata),
      .rdata_i (rdata_i),
      .wstrb_o (strb),
      .wdata_o (wrep),
      .ldata_o (ldata)
   );
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: if (req_valid_i) begin
            req_d   = '{we: req_we_i, addr: eff_addr, wdata: req_wdata_i, size: req_size, uns: req_unsigned_i};
            rdata_d = '0;
            err_d   = req_err;
            state_d = req_err ? RESP : ISSUE;
         end
         ISSUE: state_d = req_q.we ? RESP : WAIT;
         WAIT: begin
            rdata_d = ldata;
            state_d = RESP;
         end
         RESP: state_d = rsp_ready_i ? IDLE : RESP;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   // dmem enables drop immediately on reset so an interrupted ISSUE never writes
   assign issue       = state_q == ISSUE;
   assign re_o        = issue && !req_q.we && !rst_i;
   assign we_o        = issue && req_q.we && !rst_i;
   assign addr_o      = {req_q.addr[31:2], 2'b00};
   assign wdata_o     = wrep;
   assign wstrb_o     = issue ? strb : 4'b0000;
   assign req_ready_o = state_q == IDLE;
   assign rsp_valid_o = state_q == RESP;
   assign rsp_rdata_o = rdata_q;
   assign rsp_err_o   = err_q;
endmodule

// File: tb/tb_m_lsu.sv
// tb_m_lsu: directed and random requests against m_lsu, checked with a byte-level memory model.
module tb_m_lsu;
   localparam int DMEM = 1024;
   logic        clk_i = 1'b0, rst_i = 1'b1, fill = 1'b1;
   logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0, req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = '0, req_wdata_i = '0;
   logic [1:0]  req_size_i = '0;
   logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o, re_o, we_o;
   logic [31:0] rsp_rdata_o, addr_o, wdata_o, rdata_i;
   logic [3:0]  wstrb_o;
   logic [7:0]  mem [DMEM];
   logic [7:0]  ref_mem [DMEM];
   int          nchk = 0, nerr = 0;
   logic [31:0] rd;

   m_lsu #(.DMEM_BYTES(DMEM)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .rsp_valid_o(rsp_valid_o),
      .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
      .re_o(re_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
      .rdata_i(rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // dmem: byte-strobed writes, read data one cycle after re_o
   always @(posedge clk_i) begin
      if (fill) begin
         for (int i = 0; i < DMEM; i++) mem[i] <= 8'(i * 7 + 3);
      end else begin
         if (we_o)
            for (int i = 0; i < 4; i++)
               if (wstrb_o[i]) mem[int'(addr_o % DMEM) + i] <= wdata_o[8*i +: 8];
         if (re_o)
            rdata_i <= {mem[int'(addr_o % DMEM) + 3], mem[int'(addr_o % DMEM) + 2],
                        mem[int'(addr_o % DMEM) + 1], mem[int'(addr_o % DMEM)]};
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic [1:0] sz,
                      input logic uns, input int hold, output logic [31:0] rdo);
      logic        e_err;
      logic [31:0] eff, e_rd, e_wd, a_seen, s_wd;
      logic [3:0]  e_st, s_st;
      int          n, lat, nre, nwe;
      n     = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
      e_err = sz == 2'b11 || addr >= DMEM;
`ifdef LSU_ALIGN_CHECK_EN
      e_err = e_err || (addr % n) != 0;
      eff   = addr;
`else
      eff   = addr - addr % n;
`endif
      e_rd = '0;
      e_st = '0;
      e_wd = n == 1 ? {4{wd[7:0]}} : n == 2 ? {2{wd[15:0]}} : wd;
      if (!e_err)
         for (int i = 0; i < n; i++)
            if (we) begin
               e_st[int'(eff[1:0]) + i] = 1'b1;
               ref_mem[int'(eff) + i]   = wd[8*i +: 8];
            end else e_rd = e_rd | (32'(ref_mem[int'(eff) + i]) << (8 * i));
      if (!e_err && !we && !uns && n < 4 && e_rd[8*n-1]) e_rd = e_rd | ~((32'd1 << (8 * n)) - 1);
      req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_size_i = sz; req_unsigned_i = uns;
      req_valid_i = 1'b1;
      chk("req_ready", req_ready_o, 1);
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      lat = 0; nre = 0; nwe = 0; a_seen = '0; s_wd = '0; s_st = '0;
      for (int k = 1; k <= 8; k++) begin
         if (re_o) begin nre++; a_seen = addr_o; end
         if (we_o) begin nwe++; a_seen = addr_o; s_st = wstrb_o; s_wd = wdata_o; end
         if (rsp_valid_o) begin lat = k; break; end
         @(posedge clk_i); #1;
      end
      chk("latency", lat, e_err ? 1 : we ? 2 : 3);
      chk("rsp_err", rsp_err_o, e_err);
      chk("rsp_rdata", rsp_rdata_o, e_rd);
      chk("re_cycles", nre, !e_err && !we);
      chk("we_cycles", nwe, !e_err && we);
      if (!e_err) chk("addr_o", a_seen, {eff[31:2], 2'b00});
      if (!e_err && we) begin
         chk("wstrb_o", s_st, e_st);
         chk("wdata_o", s_wd, e_wd);
      end
      rdo = rsp_rdata_o;
      if (hold > 0) begin
         repeat (hold) begin @(posedge clk_i); #1; end
         chk("hold_valid", rsp_valid_o, 1);
         chk("hold_rdata", rsp_rdata_o, e_rd);
         chk("hold_err", rsp_err_o, e_err);
         chk("hold_ready", req_ready_o, 0);
      end
      rsp_ready_i = 1'b1;
      @(posedge clk_i); #1;
      rsp_ready_i = 1'b0;
      chk("back_idle", req_ready_o, 1);
      chk("rsp_dropped", rsp_valid_o, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DMEM; i++) ref_mem[i] = 8'(i * 7 + 3);
      repeat (3) @(posedge clk_i);
      #1;
      rst_i = 1'b0; fill = 1'b0;
      chk("rst_ready", req_ready_o, 1);
      chk("rst_valid", rsp_valid_o, 0);
      chk("rst_rdata", rsp_rdata_o, 0);
      chk("rst_err", rsp_err_o, 0);
      chk("rst_re", re_o, 0);
      chk("rst_we", we_o, 0);
      txn(1, 32'h100, 32'hDEADBEEF, 2'b10, 0, 0, rd);
      txn(1, 32'h100, 32'h80FF0011, 2'b10, 0, 0, rd);
      txn(0, 32'h103, 0, 2'b00, 0, 0, rd);
      chk("ldb_signed", rd, 32'hFFFFFF80);
      txn(0, 32'h103, 0, 2'b00, 1, 0, rd);
      chk("ldb_unsigned", rd, 32'h00000080);
      txn(1, 32'h102, 32'h00001234, 2'b01, 0, 0, rd);
      txn(0, 32'h102, 0, 2'b01, 1, 0, rd);
      chk("ldh_unsigned", rd, 32'h00001234);
      txn(0, 32'h102, 0, 2'b10, 0, 0, rd);
      txn(0, 32'h104, 0, 2'b11, 0, 0, rd);
      txn(1, DMEM, 32'h55, 2'b00, 0, 0, rd);
      txn(1, DMEM - 1, 32'hA5, 2'b00, 0, 0, rd);
      txn(0, DMEM - 1, 0, 2'b00, 0, 0, rd);
      txn(0, 32'h100, 0, 2'b10, 0, 5, rd);
      txn(1, 32'h200, 32'hCAFEF00D, 2'b10, 0, 0, rd);
      req_we_i = 1'b1; req_addr_i = 32'h200; req_wdata_i = 32'h11111111; req_size_i = 2'b10;
      req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      chk("issue_we", we_o, 1);
      rst_i = 1'b1;
      #1;
      chk("rst_gates_we", we_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      chk("ready_after_rst", req_ready_o, 1);
      chk("valid_after_rst", rsp_valid_o, 0);
      txn(0, 32'h200, 0, 2'b10, 0, 0, rd);
      chk("no_write_on_rst", rd, 32'hCAFEF00D);
      for (int t = 0; t < 80; t++)
         txn(1'($urandom % 2), ($urandom % 8 == 0) ? DMEM + $urandom % 16 : $urandom % DMEM,
             $urandom, 2'($urandom_range(0, 3)), 1'($urandom % 2), $urandom % 3, rd);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule

// File: doc/m_lsu.md
M_LSU -- requirements
Module: m_lsu

Interface
REQ-001 SHALL have parameter DMEM_BYTES, default 32768: size of the dmem byte address space; any address >= DMEM_BYTES is out of range.
REQ-002 SHALL have port clk_i, input, 1: the single clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have ports req_valid_i (in, 1) and req_ready_o (out, 1): request handshake.
REQ-005 SHALL have ports req_we_i (in, 1; 1 = store), req_addr_i (in, 32; byte address) and req_wdata_i (in, 32; store data in bits [7:0], [15:0] or [31:0]).
REQ-006 SHALL have ports req_size_i (in, 2; 00 = byte, 01 = half, 10 = word, 11 = illegal) and req_unsigned_i (in, 1; zero-extend loads).
REQ-007 SHALL have ports rsp_valid_o (out, 1), rsp_ready_i (in, 1), rsp_rdata_o (out, 32; extended load data, 0 for stores) and rsp_err_o (out, 1).
REQ-008 SHALL have dmem-side ports re_o (out, 1), we_o (out, 1), addr_o (out, 32), wdata_o (out, 32), wstrb_o (out, 4) and rdata_i (in, 32; valid one cycle after an re_o cycle).

Function
REQ-009 SHALL have FSM states IDLE, ISSUE, WAIT and RESP, with req_ready_o = (state == IDLE).
REQ-010 SHALL register the request on accept (req_valid_i && req_ready_o); a request never touches dmem in its accept cycle.
REQ-011 SHALL, from IDLE on accept, go to RESP with rsp_err_o = 1 if the request is an error (REQ-017), otherwise go to ISSUE.
REQ-012 SHALL, in ISSUE, assert exactly one of re_o/we_o for exactly one cycle, then go to WAIT for a load or RESP for a store.
REQ-013 SHALL, in WAIT, capture the extended rdata_i into rsp_rdata_o and go to RESP.
REQ-014 SHALL, in RESP, hold rsp_valid_o = 1 and keep rsp_rdata_o/rsp_err_o stable until rsp_ready_i = 1, then go to IDLE; no new request is accepted in the same cycle.
REQ-015 SHALL have latency from accept cycle N to first rsp_valid_o cycle of: load N+3, store N+2, error N+1.
REQ-016 SHALL drive addr_o = {addr[31:2], 2'b00}; wstrb_o: byte 4'b0001<<a, half 4'b0011<<a, word 4'b1111; wdata_o: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata; where a = addr[1:0].
REQ-017 SHALL treat a request as an error, with no dmem access, if req_size_i = 11, if the address is out of range, or if it is misaligned with LSU_ALIGN_CHECK_EN defined.
REQ-018 SHALL build load data as rdata_i >> (8*a), truncated to the access size, then sign-extended or zero-extended per req_unsigned_i; a word load is unchanged.
REQ-019 SHALL hold re_o, we_o and wstrb_o at 0 outside ISSUE; addr_o and wdata_o are don't-care when re_o and we_o are both 0.

Reset
REQ-020 SHALL, on rst_i, go to IDLE and clear rsp_valid_o, rsp_rdata_o, rsp_err_o and all registered request fields to 0.
REQ-021 SHALL gate we_o and re_o with !rst_i combinationally, so a reset asserted during ISSUE performs no dmem write.
REQ-022 SHALL drop an in-flight request or a pending response on reset; req_ready_o is 1 in the first cycle after reset deasserts.

Configuration
REQ-023 SHALL, with LSU_ALIGN_CHECK_EN defined, treat a misaligned access (half with a[0] = 1, word with a != 0) as an error response with no access.
REQ-024 SHALL, without LSU_ALIGN_CHECK_EN, force the misaligned low address bits to 0 (half clears a[0], word clears a[1:0]) and perform the access; rsp_err_o = 0.

Structure
REQ-025 SHALL keep the size encodings (SZ_B, SZ_H, SZ_W), the FSM state encodings and DMEM_BYTES's default in shared package lsu_pkg.
REQ-026 SHALL place strobe/replication generation and load shift/extension in one combinational sub-module m_lsu_align, instantiated once.

Verification
REQ-027 SHALL check: store word 0xDEADBEEF to 0x100 -> ISSUE cycle with we_o = 1, addr_o = 0x100, wstrb_o = 1111; rsp_valid_o at N+2 with err = 0.
REQ-028 SHALL check: load byte signed from 0x103 with mem[0x100] = 0x80FF0011 -> rsp_rdata_o = 0xFFFFFF80 at N+3; unsigned -> 0x00000080.
REQ-029 SHALL check: store half 0x1234 to 0x102 -> wstrb_o = 1100, wdata_o = 0x12341234; a following load half unsigned from 0x102 returns 0x00001234.
REQ-030 SHALL check: load word at 0x102 -> err at N+1 with no re_o when LSU_ALIGN_CHECK_EN is defined; without it, addr_o = 0x100 and data is returned.
REQ-031 SHALL check: request with size 11, or with address DMEM_BYTES -> rsp_err_o = 1, re_o = we_o = 0 throughout.
REQ-032 SHALL check: rsp_ready_i held 0 for 5 cycles -> response stable and req_ready_o = 0; rst_i asserted during a store's ISSUE -> no write (the word's previous value is read back) and req_ready_o = 1 after reset.
